free_list: RTL
==============

# free_list

Circular FIFO of unallocated physical register tags, placed directly upstream of the map table in the R10K rename stage. At dispatch it supplies the tag written into `Map_Table.free_reg` for the instruction's destination. At retirement it takes back the superseded (old) tag. On a branch mispredict it rewinds its head pointer to a checkpoint, which reclaims tags allocated on the wrong path.

## Interface
Parameters:
- `NUM_GEN_REG`, default `` `NUM_GEN_REG `` (32): architectural registers; also the first tag held after reset.
- `NUM_PHYS_REG`, default `` `NUM_PHYS_REG `` (64): physical registers.
- `FL_SIZE`, default `NUM_PHYS_REG-NUM_GEN_REG` (32): number of entries; must be a power of two.

Ports (PTR_W = $clog2(FL_SIZE)+1, i.e. index bits plus a wrap bit):
- `clock`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  dispatch pop request for this cycle.
- `retire_en`  in  1  push the tag on `retire_tag`.
- `retire_tag`  in  PHYS_REG  old tag freed at retirement; the ready bit is ignored.
- `rollback_en`  in  1  restore the head pointer from `rollback_head`.
- `rollback_head`  in  PTR_W  checkpointed head value from the branch stack.
- `free_reg`  out  PHYS_REG  tag at the head; ready bit (MSB) is always 0.
- `free_valid`  out  1  list is non-empty.
- `head_out`  out  PTR_W  current head pointer, captured by the branch stack at each branch dispatch.
- `num_free`  out  $clog2(FL_SIZE)+1  occupancy, from 0 to FL_SIZE.

## Operation
- Storage: FL_SIZE entries, each $clog2(NUM_PHYS_REG) bits wide. Only the tag index is stored; the ready bit is never stored.
- Reset (`reset`=0, asynchronous):
  - entry[i] = NUM_GEN_REG+i.
  - head = 0.
  - tail = {1'b1, 0}, i.e. full.
  - Outputs: `num_free`=FL_SIZE, `free_valid`=1, `free_reg`=NUM_GEN_REG with MSB 0, `head_out`=0.
- Pop: `enable && free_valid` → head+1. `enable` while empty is ignored; the dispatch stage must stall on `!free_valid`.
- Push: `retire_en` writes entry[tail[PTR_W-2:0]] = retire_tag index bits, then tail+1.
  - A push while full is illegal: it is ignored and flagged by a simulation assertion.
- Rollback: `rollback_en` → head = rollback_head.
  - Rollback has priority over pop in the same cycle; the pop is dropped.
  - A push in the same cycle is still performed.
- Occupancy: `num_free` = tail − head, computed in PTR_W-bit modular arithmetic.
  - Empty when head == tail.
  - Full when the index bits are equal and the wrap bits differ.
- Wrap-around: pointers increment modulo 2·FL_SIZE, so the index wraps from FL_SIZE−1 to 0 and the wrap bit toggles.

## Timing
- `free_reg`, `free_valid`, `head_out` and `num_free` are combinational from registered state, so they are valid in the same cycle `enable` is sampled.
- The pop, push and rollback effects all become visible after the next rising edge.
- No bypass from push to pop: a tag pushed in cycle N can first be popped in cycle N+1. When the list is empty, a simultaneous push and pop gives no pop and `num_free`=1 afterwards.
- Simultaneous pop and push when non-empty and not full: `num_free` is unchanged and the head entry advances.
- A reset asserted mid-operation discards all in-flight state immediately, without waiting for a clock edge.

## Structure
- Shared package `sys_defs.vh`:
  - `PHYS_REG` and `GEN_REG` already exist there.
  - Add `FL_PTR_T` (PTR_W bits) so the branch stack can use the same checkpoint type.
- Single module `free_list` with no sub-module. Pointer and occupancy logic live inline, since the FIFO is too small to warrant splitting.

## Test plan
- Reset → `num_free`=32, `free_valid`=1, `free_reg`=32 (MSB 0).
- 32 consecutive pops → `free_reg` sequence 32…63, then `free_valid`=0 and `num_free`=0. A 33rd pop changes nothing.
- From empty, push tag 5 with `enable` held high → no pop that cycle. Next cycle `free_reg`=5, `num_free`=1.
- From reset: record `head_out`=0, pop 3 tags, then assert `rollback_en` with `rollback_head`=0 → `free_reg`=32, `num_free`=32.
- Pop and push (tag 7) in the same cycle from reset-minus-one state → `num_free` is unchanged. Tag 7 reappears after the pointer wraps.
- Assert `reset` low between clock edges mid-stream → outputs show reset values before the next `clock` edge.

Source files
------------

// File: rtl/free_list_pkg.sv
// Shared rename-stage types: physical/architectural tag types and the free-list
// checkpoint pointer captured by the branch stack.
package free_list_pkg;

    localparam int DEF_NUM_GEN_REG  = 32;
    localparam int DEF_NUM_PHYS_REG = 64;
    localparam int DEF_FL_SIZE      = DEF_NUM_PHYS_REG - DEF_NUM_GEN_REG;

    localparam int PHYS_IDX_W = $clog2(DEF_NUM_PHYS_REG);
    localparam int GEN_IDX_W  = $clog2(DEF_NUM_GEN_REG);
    localparam int FL_PTR_W   = $clog2(DEF_FL_SIZE) + 1;

    // MSB is the ready bit, the rest is the physical tag index
    typedef logic [PHYS_IDX_W:0]   PHYS_REG;
    typedef logic [GEN_IDX_W-1:0]  GEN_REG;
    typedef logic [FL_PTR_W-1:0]   FL_PTR_T;

endpackage

// File: rtl/free_list.sv
// Circular FIFO of unallocated physical tags: pops at dispatch, pushes at retire,
// head rewinds on mispredict. Outputs are combinational from state; one-cycle update.
module free_list
    import free_list_pkg::*;
#(
    parameter int NUM_GEN_REG  = DEF_NUM_GEN_REG,
    parameter int NUM_PHYS_REG = DEF_NUM_PHYS_REG,
    parameter int FL_SIZE      = NUM_PHYS_REG - NUM_GEN_REG,
    localparam int TAG_W       = $clog2(NUM_PHYS_REG),
    localparam int IDX_W       = $clog2(FL_SIZE),
    localparam int PTR_W       = IDX_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             retire_en,
    input  logic [TAG_W:0]   retire_tag,
    input  logic             rollback_en,
    input  logic [PTR_W-1:0] rollback_head,
    output logic [TAG_W:0]   free_reg,
    output logic             free_valid,
    output logic [PTR_W-1:0] head_out,
    output logic [PTR_W-1:0] num_free
);

    logic [TAG_W-1:0] entries [FL_SIZE];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_nxt;
    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;
    logic             unused_ready;

    // The incoming ready bit carries no information for a free tag.
    assign unused_ready = retire_tag[TAG_W];

    assign empty = (head == tail);
    assign full  = (head[IDX_W-1:0] == tail[IDX_W-1:0]) &&
                   (head[PTR_W-1] != tail[PTR_W-1]);

    // Rollback wins over a same-cycle pop; a pushed tag is not poppable until next cycle.
    assign do_pop  = enable && !empty && !rollback_en;
    assign do_push = retire_en && !full;

    always_comb begin
        head_nxt = head;
        if (rollback_en) begin
            head_nxt = rollback_head;
        end else if (do_pop) begin
            head_nxt = head + PTR_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= {1'b1, {IDX_W{1'b0}}};
            for (int i = 0; i < FL_SIZE; i++) begin
                entries[i] <= TAG_W'(NUM_GEN_REG + i);
            end
        end else begin
            head <= head_nxt;
            if (do_push) begin
                entries[tail[IDX_W-1:0]] <= retire_tag[TAG_W-1:0];
                tail                     <= tail + PTR_W'(1);
            end
        end
    end

    assign free_reg   = {1'b0, entries[head[IDX_W-1:0]]};
    assign free_valid = !empty;
    assign head_out   = head;
    assign num_free   = tail - head;

    push_while_full: assert property (@(posedge clock) disable iff (!reset)
        !(retire_en && full))
        else $error("free_list: retire push while list is full");

endmodule
